// File: rtl/sprite_pop_ctrl_pkg.sv
// Shared constants, state encodings and axis-step helpers for the popping-sprite controller.
package sprite_pop_ctrl_pkg;

    localparam int SCREEN_W_DEF = 1280;
    localparam int SCREEN_H_DEF = 720;

    localparam logic [1:0] ST_ALIVE   = 2'd0;
    localparam logic [1:0] ST_POPPING = 2'd1;
    localparam logic [1:0] ST_HIDDEN  = 2'd2;

    // Fibonacci taps 16,14,13,11 map to register bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [11:0] pos;
        logic        dir;   // 1 = moving toward larger coordinates
    } axis_t;

    function automatic axis_t axis_step(input logic [11:0] pos,
                                        input logic        dir,
                                        input logic [3:0]  speed,
                                        input logic [11:0] max);
        axis_t       res;
        logic [11:0] spd;
        spd = {8'd0, speed};
        if (dir) begin
            if (pos + spd >= max) begin
                res.pos = max;
                res.dir = 1'b0;
            end else begin
                res.pos = pos + spd;
                res.dir = 1'b1;
            end
        end else begin
            if (pos <= spd) begin
                res.pos = 12'd0;
                res.dir = 1'b1;
            end else begin
                res.pos = pos - spd;
                res.dir = 1'b0;
            end
        end
        return res;
    endfunction

    function automatic logic [11:0] wrap_clamp(input logic [11:0] r,
                                               input logic [11:0] max);
        logic [11:0] t;
        t = (r >= max) ? (r - max) : r;
        return (t > max) ? max : t;
    endfunction

endpackage

// File: rtl/sprite_pop_ctrl_lfsr_16.sv
// Free-running 16-bit Fibonacci LFSR with synchronous reset to the package seed.
module lfsr_16
    import sprite_pop_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    // Shift left, feedback is the XOR of the tapped bits
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/sprite_pop_ctrl.sv
// Frame-rate sprite sequencer: diagonal bounce, pop/hide/respawn FSM, frame-aligned outputs.
// Optional random respawn position with macro SPRITE_POP_CTRL_LFSR_RESPAWN_EN.
module sprite_pop_ctrl
    import sprite_pop_ctrl_pkg::*;
#(
    parameter int WIDTH       = 256,
    parameter int HEIGHT      = 256,
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int START_X     = 0,
    parameter int START_Y     = 0,
    parameter int POP_FRAMES  = 30,
    parameter int HIDE_FRAMES = 60
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        new_frame_in,
    input  logic        pop_req_in,
    input  logic [3:0]  speed_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        pop_out,
    output logic        visible_out,
    output logic        busy_out
);

    localparam logic [11:0] XMAX      = 12'(SCREEN_W - WIDTH);
    localparam logic [11:0] YMAX      = 12'(SCREEN_H - HEIGHT);
    localparam logic [15:0] POP_LOAD  = 16'(POP_FRAMES - 1);
    localparam logic [15:0] HIDE_LOAD = 16'(HIDE_FRAMES - 1);

    logic [1:0]  state, state_n;
    logic [15:0] cnt, cnt_n;
    logic        dx, dx_n, dy, dy_n;
    logic        pending, pending_n;
    logic [10:0] x_n;
    logic [9:0]  y_n;
    logic        pop_n, vis_n, busy_n;
    logic [10:0] respawn_x;
    logic [9:0]  respawn_y;
    axis_t       ax, ay;
    logic        unused_bits;

`ifdef SPRITE_POP_CTRL_LFSR_RESPAWN_EN
    logic [15:0] lfsr;
    logic [11:0] rx_full, ry_full;

    lfsr_16 u_lfsr (
        .clk  (pixel_clk_in),
        .rst  (rst_in),
        .lfsr (lfsr)
    );

    // Fold the random draw into the legal range so the sprite never leaves the screen
    always_comb begin
        rx_full   = wrap_clamp({1'b0, lfsr[10:0]}, XMAX);
        ry_full   = wrap_clamp({2'b00, lfsr[9:0]}, YMAX);
        respawn_x = rx_full[10:0];
        respawn_y = ry_full[9:0];
    end

    assign unused_bits = ^{ax.pos[11], ay.pos[11:10], rx_full[11], ry_full[11:10], lfsr[15:11]};
`else
    assign respawn_x   = 11'(START_X);
    assign respawn_y   = 10'(START_Y);
    assign unused_bits = ^{ax.pos[11], ay.pos[11:10]};
`endif

    // Next-state logic; everything except pop latching waits for a frame tick
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        dx_n      = dx;
        dy_n      = dy;
        x_n       = x_out;
        y_n       = y_out;
        pop_n     = pop_out;
        vis_n     = visible_out;
        busy_n    = busy_out;
        pending_n = pending;
        ax        = axis_step({1'b0, x_out}, dx, speed_in, XMAX);
        ay        = axis_step({2'b00, y_out}, dy, speed_in, YMAX);

        if ((state == ST_ALIVE) && pop_req_in) begin
            pending_n = 1'b1;
        end else begin
            pending_n = pending;
        end

        if (new_frame_in) begin
            case (state)
                ST_ALIVE: begin
                    if (pending || pop_req_in) begin
                        state_n   = ST_POPPING;
                        pop_n     = 1'b1;
                        busy_n    = 1'b1;
                        cnt_n     = POP_LOAD;
                        pending_n = 1'b0;
                    end else begin
                        x_n  = ax.pos[10:0];
                        dx_n = ax.dir;
                        y_n  = ay.pos[9:0];
                        dy_n = ay.dir;
                    end
                end
                ST_POPPING: begin
                    if (cnt == 16'd0) begin
                        state_n = ST_HIDDEN;
                        pop_n   = 1'b0;
                        vis_n   = 1'b0;
                        cnt_n   = HIDE_LOAD;
                    end else begin
                        cnt_n = cnt - 16'd1;
                    end
                end
                ST_HIDDEN: begin
                    if (cnt == 16'd0) begin
                        state_n = ST_ALIVE;
                        vis_n   = 1'b1;
                        busy_n  = 1'b0;
                        x_n     = respawn_x;
                        y_n     = respawn_y;
                        dx_n    = 1'b1;
                        dy_n    = 1'b1;
                    end else begin
                        cnt_n = cnt - 16'd1;
                    end
                end
                default: begin
                    state_n   = ST_ALIVE;
                    pop_n     = 1'b0;
                    vis_n     = 1'b1;
                    busy_n    = 1'b0;
                    cnt_n     = 16'd0;
                    pending_n = 1'b0;
                end
            endcase
        end else begin
            state_n = state;
        end
    end

    // State and output registers; reset wins over a coincident frame tick
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state       <= ST_ALIVE;
            cnt         <= 16'd0;
            dx          <= 1'b1;
            dy          <= 1'b1;
            pending     <= 1'b0;
            x_out       <= 11'(START_X);
            y_out       <= 10'(START_Y);
            pop_out     <= 1'b0;
            visible_out <= 1'b1;
            busy_out    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            dx          <= dx_n;
            dy          <= dy_n;
            pending     <= pending_n;
            x_out       <= x_n;
            y_out       <= y_n;
            pop_out     <= pop_n;
            visible_out <= vis_n;
            busy_out    <= busy_n;
        end
    end

endmodule
